hw_acc_cm_eqc_rsp_merge: RTL and testbench

Final stage of the hardware-accelerated CQ/EQ context-management path. It consumes EQC cache responses, reads back the CQC entry that the preceding stage parked in the CQC staged buffer under the same request tag, and emits one merged {EQC, CQC} context response. The response is steered to the requesting channel, which is encoded in the tag.

---
 rtl/hw_acc_cm_eqc_rsp_merge_pkg.sv | 32 +++
 rtl/hw_acc_cm_eqc_rsp_merge.sv | 132 +++++++++++++
 tb/tb_hw_acc_cm_eqc_rsp_merge.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hw_acc_cm_eqc_rsp_merge_pkg.sv
// Shared constants for the EQC/CQC response merge stage: head layout, widths,
// channel field position within the request tag, and FSM state encoding.
package hw_acc_cm_eqc_rsp_merge_pkg;

    localparam int DEF_COUNT_MAX           = 2;
    localparam int DEF_COUNT_MAX_LOG       = $clog2(DEF_COUNT_MAX) + 1;
    localparam int MAX_REQ_TAG_NUM_LOG     = 8;
    localparam int DEF_PHYSICAL_ADDR_WIDTH = 64;
    localparam int DEF_ICM_ADDR_WIDTH      = 64;
    localparam int DEF_EQC_ENTRY_WIDTH     = 256;
    localparam int CACHE_ENTRY_WIDTH_CQC   = 256;

    // Head is packed {count_total, count_index, req_tag, phy_addr, icm_addr}, MSB first.
    localparam int HEAD_ICM_ADDR_LSB    = 0;
    localparam int HEAD_PHY_ADDR_LSB    = HEAD_ICM_ADDR_LSB + DEF_ICM_ADDR_WIDTH;
    localparam int HEAD_REQ_TAG_LSB     = HEAD_PHY_ADDR_LSB + DEF_PHYSICAL_ADDR_WIDTH;
    localparam int HEAD_COUNT_INDEX_LSB = HEAD_REQ_TAG_LSB + MAX_REQ_TAG_NUM_LOG;
    localparam int HEAD_COUNT_TOTAL_LSB = HEAD_COUNT_INDEX_LSB + DEF_COUNT_MAX_LOG;
    localparam int DEF_HEAD_WIDTH       = HEAD_COUNT_TOTAL_LSB + DEF_COUNT_MAX_LOG;

    localparam int CHNL_MSB   = 7;
    localparam int CHNL_LSB   = 5;
    localparam int CHNL_WIDTH = CHNL_MSB - CHNL_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUF_RD   = 2'd1,
        ST_BUF_WAIT = 2'd2,
        ST_RSP      = 2'd3
    } merge_state_t;

endpackage

// File: rtl/hw_acc_cm_eqc_rsp_merge.sv
// Merges an EQC cache response with the CQC entry parked in the staged buffer
// under the same tag, and returns {EQC, CQC} to the channel encoded in the tag.
module hw_acc_cm_eqc_rsp_merge
    import hw_acc_cm_eqc_rsp_merge_pkg::*;
#(
    parameter int COUNT_MAX           = DEF_COUNT_MAX,
    parameter int COUNT_MAX_LOG       = $clog2(COUNT_MAX) + 1,
    parameter int REQ_TAG_WIDTH       = MAX_REQ_TAG_NUM_LOG,
    parameter int PHYSICAL_ADDR_WIDTH = DEF_PHYSICAL_ADDR_WIDTH,
    parameter int ICM_ADDR_WIDTH      = DEF_ICM_ADDR_WIDTH,
    parameter int EQC_ENTRY_WIDTH     = DEF_EQC_ENTRY_WIDTH,
    parameter int CQC_ENTRY_WIDTH     = CACHE_ENTRY_WIDTH_CQC,
    parameter int HEAD_WIDTH          = COUNT_MAX_LOG * 2 + REQ_TAG_WIDTH
                                        + PHYSICAL_ADDR_WIDTH + ICM_ADDR_WIDTH
)(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   eqc_get_rsp_valid,
    input  logic [HEAD_WIDTH-1:0]                  eqc_get_rsp_head,
    input  logic [EQC_ENTRY_WIDTH-1:0]             eqc_get_rsp_data,
    output logic                                   eqc_get_rsp_ready,
    output logic                                   cqc_buffer_ren,
    output logic [REQ_TAG_WIDTH-1:0]               cqc_buffer_raddr,
    input  logic [CQC_ENTRY_WIDTH-1:0]             cqc_buffer_dout,
    output logic                                   cm_rsp_valid,
    output logic [CHNL_WIDTH-1:0]                  cm_rsp_chnl,
    output logic [REQ_TAG_WIDTH-1:0]               cm_rsp_tag,
    output logic [EQC_ENTRY_WIDTH+CQC_ENTRY_WIDTH-1:0] cm_rsp_data,
    input  logic                                   cm_rsp_ready,
    output logic                                   proto_err,
    output logic [31:0]                            rsp_cnt
);

    merge_state_t                                   state_r;
    logic [REQ_TAG_WIDTH-1:0]                       tag_r;
    logic [EQC_ENTRY_WIDTH-1:0]                     eqc_r;
    logic                                           ren_r;
    logic [REQ_TAG_WIDTH-1:0]                       raddr_r;
    logic                                           rsp_valid_r;
    logic [CHNL_WIDTH-1:0]                          rsp_chnl_r;
    logic [REQ_TAG_WIDTH-1:0]                       rsp_tag_r;
    logic [EQC_ENTRY_WIDTH+CQC_ENTRY_WIDTH-1:0]     rsp_data_r;
    logic                                           proto_err_r;
    logic [31:0]                                    rsp_cnt_r;

    logic [REQ_TAG_WIDTH-1:0]                       head_tag_s;
    logic [COUNT_MAX_LOG-1:0]                       head_count_total_s;
    logic                                           unused_head_s;

    assign head_tag_s         = eqc_get_rsp_head[HEAD_REQ_TAG_LSB +: REQ_TAG_WIDTH];
    assign head_count_total_s = eqc_get_rsp_head[HEAD_COUNT_TOTAL_LSB +: COUNT_MAX_LOG];

    // Addresses and fragment index travel with the head but play no part in the merge.
    assign unused_head_s = ^{eqc_get_rsp_head[HEAD_COUNT_INDEX_LSB +: COUNT_MAX_LOG],
                             eqc_get_rsp_head[HEAD_PHY_ADDR_LSB +: PHYSICAL_ADDR_WIDTH],
                             eqc_get_rsp_head[HEAD_ICM_ADDR_LSB +: ICM_ADDR_WIDTH]};

    assign eqc_get_rsp_ready = (state_r == ST_IDLE);
    assign cqc_buffer_ren    = ren_r;
    assign cqc_buffer_raddr  = raddr_r;
    assign cm_rsp_valid      = rsp_valid_r;
    assign cm_rsp_chnl       = rsp_chnl_r;
    assign cm_rsp_tag        = rsp_tag_r;
    assign cm_rsp_data       = rsp_data_r;
    assign proto_err         = proto_err_r;
    assign rsp_cnt           = rsp_cnt_r;

    // Merge FSM: accept head, read staged buffer, capture CQC, hold response until taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            tag_r       <= '0;
            eqc_r       <= '0;
            ren_r       <= 1'b0;
            raddr_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_chnl_r  <= '0;
            rsp_tag_r   <= '0;
            rsp_data_r  <= '0;
            proto_err_r <= 1'b0;
            rsp_cnt_r   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (eqc_get_rsp_valid) begin
                        state_r <= ST_BUF_RD;
                        tag_r   <= head_tag_s;
                        eqc_r   <= eqc_get_rsp_data;
                        ren_r   <= 1'b1;
                        raddr_r <= head_tag_s;
                        if (head_count_total_s == '0) begin
                            proto_err_r <= 1'b1;
                        end
                    end
                end
                ST_BUF_RD: begin
                    state_r <= ST_BUF_WAIT;
                    ren_r   <= 1'b0;
                    raddr_r <= '0;
                end
                ST_BUF_WAIT: begin
                    // Buffer read data is valid now, one cycle after the read enable.
                    state_r     <= ST_RSP;
                    rsp_valid_r <= 1'b1;
                    rsp_chnl_r  <= tag_r[CHNL_MSB:CHNL_LSB];
                    rsp_tag_r   <= tag_r;
                    rsp_data_r  <= {eqc_r, cqc_buffer_dout};
                end
                ST_RSP: begin
                    if (cm_rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_chnl_r  <= '0;
                        rsp_tag_r   <= '0;
                        rsp_data_r  <= '0;
                        rsp_cnt_r   <= rsp_cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ren_r       <= 1'b0;
                    raddr_r     <= '0;
                    rsp_valid_r <= 1'b0;
                    rsp_chnl_r  <= '0;
                    rsp_tag_r   <= '0;
                    rsp_data_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hw_acc_cm_eqc_rsp_merge.sv
// Self-checking bench for hw_acc_cm_eqc_rsp_merge: directed table, back-to-back,
// randomized transactions against a transaction-level model, wrap and reset cases.
`timescale 1ns/1ps
module tb_hw_acc_cm_eqc_rsp_merge;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           eqc_get_rsp_valid;
    logic [139:0]   eqc_get_rsp_head;
    logic [255:0]   eqc_get_rsp_data;
    logic           eqc_get_rsp_ready;
    logic           cqc_buffer_ren;
    logic [7:0]     cqc_buffer_raddr;
    logic [255:0]   cqc_buffer_dout;
    logic           cm_rsp_valid;
    logic [2:0]     cm_rsp_chnl;
    logic [7:0]     cm_rsp_tag;
    logic [511:0]   cm_rsp_data;
    logic           cm_rsp_ready;
    logic           proto_err;
    logic [31:0]    rsp_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model state
    logic [255:0] buf_mem [256];
    logic [31:0]  model_cnt;
    logic         model_perr;

    hw_acc_cm_eqc_rsp_merge dut (
        .clk               (clk),
        .rst               (rst),
        .eqc_get_rsp_valid (eqc_get_rsp_valid),
        .eqc_get_rsp_head  (eqc_get_rsp_head),
        .eqc_get_rsp_data  (eqc_get_rsp_data),
        .eqc_get_rsp_ready (eqc_get_rsp_ready),
        .cqc_buffer_ren    (cqc_buffer_ren),
        .cqc_buffer_raddr  (cqc_buffer_raddr),
        .cqc_buffer_dout   (cqc_buffer_dout),
        .cm_rsp_valid      (cm_rsp_valid),
        .cm_rsp_chnl       (cm_rsp_chnl),
        .cm_rsp_tag        (cm_rsp_tag),
        .cm_rsp_data       (cm_rsp_data),
        .cm_rsp_ready      (cm_rsp_ready),
        .proto_err         (proto_err),
        .rsp_cnt           (rsp_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Staged buffer: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk) begin
        if (cqc_buffer_ren) cqc_buffer_dout <= buf_mem[cqc_buffer_raddr];
        else                cqc_buffer_dout <= rand256();
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [139:0] make_head(input logic [7:0] tag, input logic [1:0] ct);
        logic [63:0] pa;
        logic [63:0] ia;
        logic [1:0]  ci;
        pa = {$urandom, $urandom};
        ia = {$urandom, $urandom};
        ci = 2'($urandom);
        return {ct, ci, tag, pa, ia};
    endfunction

    // One full transaction, starting just after a negedge with the DUT idle.
    task automatic run_txn(input logic [7:0] tag, input logic [1:0] ct, input logic [255:0] eqc,
                           input int bp, input logic [2:0] exp_chnl, input logic exp_perr);
        logic [511:0] exp_data;
        exp_data = {eqc, buf_mem[tag]};
        chk("idle_ready", 512'(eqc_get_rsp_ready), 512'(1'b1));
        eqc_get_rsp_valid = 1'b1;
        eqc_get_rsp_head  = make_head(tag, ct);
        eqc_get_rsp_data  = eqc;
        @(posedge clk); #1;
        eqc_get_rsp_valid = 1'b0;
        eqc_get_rsp_head  = make_head(8'(~tag), 2'd1);
        eqc_get_rsp_data  = rand256();
        cm_rsp_ready      = 1'($urandom);
        chk("ren_t1", 512'(cqc_buffer_ren), 512'(1'b1));
        chk("raddr_t1", 512'(cqc_buffer_raddr), 512'(tag));
        chk("busy_ready", 512'(eqc_get_rsp_ready), 512'(1'b0));
        @(posedge clk); #1;
        cm_rsp_ready = 1'($urandom);
        chk("ren_t2", 512'(cqc_buffer_ren), 512'(1'b0));
        chk("raddr_t2", 512'(cqc_buffer_raddr), 512'(8'd0));
        chk("valid_t2", 512'(cm_rsp_valid), 512'(1'b0));
        @(posedge clk); #1;
        for (int k = 0; k <= bp; k++) begin
            chk("rsp_valid", 512'(cm_rsp_valid), 512'(1'b1));
            chk("rsp_chnl", 512'(cm_rsp_chnl), 512'(exp_chnl));
            chk("rsp_tag", 512'(cm_rsp_tag), 512'(tag));
            chk("rsp_data", cm_rsp_data, exp_data);
            chk("rsp_busy_ready", 512'(eqc_get_rsp_ready), 512'(1'b0));
            chk("proto_err", 512'(proto_err), 512'(exp_perr));
            cm_rsp_ready = (k == bp);
            @(posedge clk); #1;
        end
        cm_rsp_ready = 1'b0;
        model_cnt    = model_cnt + 32'd1;
        chk("post_valid", 512'(cm_rsp_valid), 512'(1'b0));
        chk("post_data", cm_rsp_data, 512'(0));
        chk("post_tag", 512'({cm_rsp_chnl, cm_rsp_tag}), 512'(0));
        chk("post_ready", 512'(eqc_get_rsp_ready), 512'(1'b1));
        chk("rsp_cnt", 512'(rsp_cnt), 512'(model_cnt));
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]   tag;
        logic [1:0]   ct;
        logic [255:0] eqc;
        logic [255:0] cqc;
        int           bp;
        logic [2:0]   exp_chnl;
        logic         exp_perr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0]   b2b_tag  [4];
        logic [2:0]   b2b_chnl [4];
        logic [255:0] b2b_eqc  [4];
        int idx, got, last_acc, seen;
        logic acc;
        logic [7:0] rtag;
        logic [1:0] rct;
        logic [255:0] reqc;

        for (int i = 0; i < 256; i++) buf_mem[i] = '0;
        eqc_get_rsp_valid = 1'b0;
        eqc_get_rsp_head  = '0;
        eqc_get_rsp_data  = '0;
        cm_rsp_ready      = 1'b0;
        model_cnt         = 32'd0;
        model_perr        = 1'b0;

        vecs[0] = '{8'h45, 2'd1, {32{8'hA5}}, {32{8'h3C}}, 0, 3'd2, 1'b0};
        vecs[1] = '{8'h45, 2'd2, {32{8'h5A}}, {32{8'hC3}}, 5, 3'd2, 1'b0};
        vecs[2] = '{8'h00, 2'd1, rand256(),   rand256(),   0, 3'd0, 1'b0};
        vecs[3] = '{8'h20, 2'd1, rand256(),   rand256(),   1, 3'd1, 1'b0};
        vecs[4] = '{8'hE0, 2'd2, rand256(),   rand256(),   0, 3'd7, 1'b0};
        vecs[5] = '{8'hFF, 2'd1, rand256(),   rand256(),   2, 3'd7, 1'b0};
        vecs[6] = '{8'h10, 2'd0, rand256(),   rand256(),   0, 3'd0, 1'b1};
        vecs[7] = '{8'h33, 2'd2, rand256(),   rand256(),   1, 3'd1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ren", 512'(cqc_buffer_ren), 512'(1'b0));
        chk("rst_valid", 512'(cm_rsp_valid), 512'(1'b0));
        chk("rst_data", cm_rsp_data, 512'(0));
        chk("rst_cnt_err", 512'({rsp_cnt, proto_err}), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_ready", 512'(eqc_get_rsp_ready), 512'(1'b1));
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            buf_mem[vecs[i].tag] = vecs[i].cqc;
            run_txn(vecs[i].tag, vecs[i].ct, vecs[i].eqc, vecs[i].bp,
                    vecs[i].exp_chnl, vecs[i].exp_perr);
        end
        model_perr = 1'b1;

        // Back-to-back with consumer always ready
        b2b_tag  = '{8'h00, 8'h20, 8'hE0, 8'hFF};
        b2b_chnl = '{3'd0, 3'd1, 3'd7, 3'd7};
        for (int i = 0; i < 4; i++) begin
            b2b_eqc[i] = rand256();
            buf_mem[b2b_tag[i]] = rand256();
        end
        cm_rsp_ready = 1'b1;
        idx = 0; got = 0; last_acc = -1;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            if (idx < 4) begin
                eqc_get_rsp_valid = 1'b1;
                eqc_get_rsp_head  = make_head(b2b_tag[idx], 2'd1);
                eqc_get_rsp_data  = b2b_eqc[idx];
            end else begin
                eqc_get_rsp_valid = 1'b0;
            end
            acc = (idx < 4) && eqc_get_rsp_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (idx > 0) chk("b2b_gap", 512'(cyc - last_acc), 512'(4));
                last_acc = cyc;
                idx++;
            end
            if (cm_rsp_valid) begin
                chk("b2b_chnl", 512'(cm_rsp_chnl), 512'(b2b_chnl[got]));
                chk("b2b_tag", 512'(cm_rsp_tag), 512'(b2b_tag[got]));
                chk("b2b_data", cm_rsp_data, {b2b_eqc[got], buf_mem[b2b_tag[got]]});
                got++;
            end
            @(negedge clk);
        end
        eqc_get_rsp_valid = 1'b0;
        chk("b2b_count", 512'(got), 512'(4));
        @(posedge clk); #1;
        cm_rsp_ready = 1'b0;
        model_cnt = model_cnt + 32'd4;
        chk("b2b_rsp_cnt", 512'(rsp_cnt), 512'(model_cnt));
        @(negedge clk);

        // Randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            rtag = 8'($urandom);
            rct  = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            reqc = rand256();
            buf_mem[rtag] = rand256();
            model_perr = model_perr | (rct == 2'd0);
            run_txn(rtag, rct, reqc, $urandom_range(0, 3), 3'(rtag / 8'd32), model_perr);
        end

        // Counter wrap
        force dut.rsp_cnt_r = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.rsp_cnt_r;
        model_cnt = 32'hFFFF_FFFF;
        buf_mem[8'h5C] = rand256();
        run_txn(8'h5C, 2'd1, rand256(), 0, 3'd2, model_perr);

        // Reset while waiting on buffer data
        buf_mem[8'h77] = rand256();
        eqc_get_rsp_valid = 1'b1;
        eqc_get_rsp_head  = make_head(8'h77, 2'd1);
        eqc_get_rsp_data  = rand256();
        @(posedge clk); #1;
        eqc_get_rsp_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 512'(cm_rsp_valid), 512'(1'b0));
        chk("mid_rst_data", cm_rsp_data, 512'(0));
        chk("mid_rst_ren", 512'({cqc_buffer_ren, cqc_buffer_raddr}), 512'(0));
        chk("mid_rst_err", 512'(proto_err), 512'(1'b0));
        chk("mid_rst_cnt", 512'(rsp_cnt), 512'(0));
        chk("mid_rst_ready", 512'(eqc_get_rsp_ready), 512'(1'b1));
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (cm_rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", 512'(seen), 512'(0));
        @(negedge clk);
        model_cnt  = 32'd0;
        model_perr = 1'b0;
        buf_mem[8'hA1] = rand256();
        run_txn(8'hA1, 2'd1, rand256(), 1, 3'd5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
